crc8_feeder: RTL and testbench

CRC8_FEEDER -- requirements
Module: crc8_feeder

---
 rtl/crc8_feeder_if.sv | 45 ++++
 rtl/crc8_feeder.sv | 181 ++++++++++++++++++
 tb/tb_crc8_feeder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc8_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : crc8_feeder_if
// Brief    : Symbol stream + crc8 engine signals of crc8_feeder.
//            CRC_FEEDER_TIMEOUT_EN adds the timeout_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
interface crc8_feeder_if;
    logic       s_valid_i;
    logic [4:0] s_data_i;
    logic       s_last_i;
    logic       s_ready_o;
    logic [4:0] crc_val_o;
    logic       crc_start_o;
    logic       crc_rst_o;
    logic       crc_busy_i;
    logic [7:0] crc_result_i;
    logic       frame_done_o;
    logic [7:0] crc_o;
    logic [7:0] frame_len_o;
`ifdef CRC_FEEDER_TIMEOUT_EN
    logic       timeout_o;
`endif

    // Feeder side
    modport slave (
        input  s_valid_i, s_data_i, s_last_i, crc_busy_i, crc_result_i,
        output s_ready_o, crc_val_o, crc_start_o, crc_rst_o,
               frame_done_o, crc_o, frame_len_o
`ifdef CRC_FEEDER_TIMEOUT_EN
        , output timeout_o
`endif
    );

    // Environment side: upstream source, crc8 engine, result consumer
    modport master (
        output s_valid_i, s_data_i, s_last_i, crc_busy_i, crc_result_i,
        input  s_ready_o, crc_val_o, crc_start_o, crc_rst_o,
               frame_done_o, crc_o, frame_len_o
`ifdef CRC_FEEDER_TIMEOUT_EN
        , input timeout_o
`endif
    );
endinterface
`default_nettype wire

// File: rtl/crc8_feeder.sv
`default_nettype none
// ============================================================================
// Module   : crc8_feeder
// Brief    : Buffers 5-bit symbols and feeds them one at a time to a crc8
//            engine, reporting per-frame CRC and length.
//            Optional macro CRC_FEEDER_TIMEOUT_EN: WAIT timeout with frame drop.
// Revision : 1.0 - initial release
// ============================================================================
module crc8_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    crc8_feeder_if.slave  bus
);
    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_ADDR_W:0] c_PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // FIFO: entry = {last, data}
    logic [5:0]        r_mem [FIFO_DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [5:0]        w_head;

    state_t            r_state;
    logic [4:0]        r_val;
    logic              r_last;
    logic [7:0]        r_count;
    logic              r_start;
    logic              r_done;
    logic              r_crc_rst;
    logic [7:0]        r_crc;
    logic [7:0]        r_len;

`ifdef CRC_FEEDER_TIMEOUT_EN
    localparam logic [5:0] c_TIMEOUT = 6'd32;
    logic [5:0]        r_wait_cnt;
    logic              r_drop;
    logic              w_timeout;

    // Fires on the 33rd consecutive busy cycle of WAIT
    assign w_timeout     = (r_state == S_WAIT) && bus.crc_busy_i && (r_wait_cnt == c_TIMEOUT);
    assign bus.timeout_o = w_timeout;
`endif

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_push  = bus.s_valid_i && !w_full;
    assign w_head  = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
            S_WAIT:  w_pop = !w_empty && !bus.crc_busy_i && !r_last;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= {bus.s_last_i, bus.s_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_val      <= '0;
            r_last     <= 1'b0;
            r_count    <= '0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_crc_rst  <= 1'b0;
            r_crc      <= '0;
            r_len      <= '0;
`ifdef CRC_FEEDER_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_drop     <= 1'b0;
`endif
        end else begin
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_crc_rst <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
`ifdef CRC_FEEDER_TIMEOUT_EN
                        if (r_drop) begin
                            r_drop <= !w_head[5];
                        end else
`endif
                        begin
                            r_val   <= w_head[4:0];
                            r_last  <= w_head[5];
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: r_state <= S_ARM;
                S_ARM: begin
`ifdef CRC_FEEDER_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.crc_busy_i) begin
                        // The last symbol is counted by the +1 taken in DONE
                        if (r_last) begin
                            r_state <= S_DONE;
                        end else begin
                            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
                            if (!w_empty) begin
                                r_val   <= w_head[4:0];
                                r_last  <= w_head[5];
                                r_start <= 1'b1;
                                r_state <= S_ISSUE;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
`ifdef CRC_FEEDER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_crc_rst <= 1'b1;
                        r_count   <= '0;
                        r_drop    <= !r_last;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 6'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_crc     <= bus.crc_result_i;
                    r_len     <= (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
                    r_done    <= 1'b1;
                    r_crc_rst <= 1'b1;
                    r_count   <= '0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready_o    = !w_full;
    assign bus.crc_val_o    = r_val;
    assign bus.crc_start_o  = r_start;
    // The engine is re-initialised in the same cycle as our own reset
    assign bus.crc_rst_o    = r_crc_rst | rst_i;
    assign bus.frame_done_o = r_done;
    assign bus.crc_o        = r_crc;
    assign bus.frame_len_o  = r_len;
endmodule
`default_nettype wire

// File: tb/tb_crc8_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc8_feeder
// Brief    : Self-checking bench for crc8_feeder with a crc8 engine stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc8_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    crc8_feeder_if bus ();
    crc8_feeder #(.FIFO_DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Reference CRC-8 (poly 0x07), 5-bit symbol MSB first
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [4:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 4; i >= 0; i--) begin
            fb = r[7] ^ d[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    // crc8 engine stub
    logic [7:0] stub_acc = 8'h00;
    int         stub_cnt = 0;
    int         busy_len = 11;
    logic       hold_busy = 1'b0;
    logic       fixed_res = 1'b0;
    always @(posedge clk) begin
        if (bus.crc_rst_o)        stub_acc <= 8'h00;
        else if (bus.crc_start_o) stub_acc <= crc_step(stub_acc, bus.crc_val_o);
        if (bus.crc_start_o)      stub_cnt <= busy_len;
        else if (stub_cnt > 0)    stub_cnt <= stub_cnt - 1;
    end
    assign bus.crc_busy_i   = hold_busy || (stub_cnt > 0);
    assign bus.crc_result_i = fixed_res ? 8'h5A : stub_acc;

    // Monitor
    int          cyc = 0;
    logic [4:0]  started_q [$];
    logic [15:0] done_q [$];
    int          rst_pulses = 0;
    int          last_start = 0;
    int          min_gap = 1000;
    bit          have_start = 0;
    bit          have_cur = 0;
    logic [4:0]  cur_val = 5'd0;
    int          val_viol = 0;
    int          to_count = 0;
    int          to_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst) begin
            have_cur = 0;
        end else begin
            if (bus.crc_start_o) begin
                started_q.push_back(bus.crc_val_o);
                if (have_start && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
                last_start = cyc;
                have_start = 1;
                have_cur   = 1;
                cur_val    = bus.crc_val_o;
            end
            if (have_cur && bus.crc_busy_i && bus.crc_val_o !== cur_val) val_viol++;
            if (bus.crc_rst_o) rst_pulses++;
            if (bus.frame_done_o) done_q.push_back({bus.crc_o, bus.frame_len_o});
`ifdef CRC_FEEDER_TIMEOUT_EN
            if (bus.timeout_o) begin
                to_count++;
                to_cyc = cyc;
            end
`endif
        end
    end

    int accepts = 0;
    int first_stall = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_sym(input logic [4:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        bus.s_last_i  = l;
        while (!bus.s_ready_o && guard < 5000) begin
            if (first_stall < 0) first_stall = accepts;
            @(negedge clk);
            guard++;
        end
        if (!bus.s_ready_o) chk("push_ready_timeout", 32'(bus.s_ready_o), 32'd1);
        else begin
            @(posedge clk);
            accepts++;
        end
        #1 bus.s_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_count", done_q.size(), n);
    endtask

    task automatic cmp_starts(input logic [4:0] exp_q [$]);
        chk("start_count", started_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < started_q.size(); i++)
            chk($sformatf("start_val[%0d]", i), started_q[i], exp_q[i]);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        started_q.delete();
        done_q.delete();
        min_gap    = 1000;
        have_start = 0;
    endtask

    logic [4:0]  exp_syms [$];
    logic [15:0] exp_res [$];
    logic [7:0]  c;
    int          rp;

    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = 5'd0;
        bus.s_last_i  = 1'b0;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_crc_rst_high", bus.crc_rst_o, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.s_ready_o, 1);
        chk("rst_crc_o", bus.crc_o, 8'h00);
        chk("rst_len", bus.frame_len_o, 8'd0);
        chk("rst_crc_rst_low", bus.crc_rst_o, 0);
        chk("rst_done", bus.frame_done_o, 0);
        chk("rst_start", bus.crc_start_o, 0);
        chk("rst_val", bus.crc_val_o, 5'd0);

        // Three-symbol frame, fixed-result stub
        clear_mon();
        fixed_res = 1'b1;
        busy_len  = 11;
        push_sym(5'h01, 1'b0);
        push_sym(5'h1F, 1'b0);
        push_sym(5'h0A, 1'b1);
        wait_done(1, 500);
        exp_syms = '{5'h01, 5'h1F, 5'h0A};
        cmp_starts(exp_syms);
        chk("gap_ge_13", 32'(min_gap >= 13), 1);
        if (done_q.size() > 0) begin
            chk("f3_crc", done_q[0][15:8], 8'h5A);
            chk("f3_len", done_q[0][7:0], 8'd3);
        end
        repeat (20) @(negedge clk);
        chk("f3_single_done", done_q.size(), 1);
        fixed_res = 1'b0;

        // Six symbols streamed into a 4-deep FIFO
        clear_mon();
        exp_syms.delete();
        c = 8'h00;
        accepts = 0;
        first_stall = -1;
        for (int i = 0; i < 6; i++) begin
            logic [4:0] d;
            d = 5'($urandom);
            exp_syms.push_back(d);
            c = crc_step(c, d);
            push_sym(d, i == 5);
        end
        wait_done(1, 500);
        // First symbol is popped at once, so the FIFO fills after depth+1 accepts
        chk("stall_after_accepts", first_stall, 5);
        cmp_starts(exp_syms);
        if (done_q.size() > 0) begin
            chk("f6_crc", done_q[0][15:8], c);
            chk("f6_len", done_q[0][7:0], 8'd6);
        end

        // Back-to-back frames of 1 and 2 symbols
        clear_mon();
        busy_len = $urandom_range(0, 12);
        rp = rst_pulses;
        begin
            logic [4:0] a, b, e;
            a = 5'($urandom);
            b = 5'($urandom);
            e = 5'($urandom);
            push_sym(a, 1'b1);
            push_sym(b, 1'b0);
            push_sym(e, 1'b1);
            wait_done(2, 500);
            if (done_q.size() > 1) begin
                chk("b2b_len0", done_q[0][7:0], 8'd1);
                chk("b2b_crc0", done_q[0][15:8], crc_step(8'h00, a));
                chk("b2b_len1", done_q[1][7:0], 8'd2);
                chk("b2b_crc1", done_q[1][15:8], crc_step(crc_step(8'h00, b), e));
            end
            chk("b2b_crc_rst_pulses", rst_pulses - rp, 2);
        end

        // Randomized frames against the reference model
        clear_mon();
        exp_syms.delete();
        exp_res.delete();
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(1, 6);
            c = 8'h00;
            busy_len = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin
                logic [4:0] d;
                d = 5'($urandom);
                exp_syms.push_back(d);
                c = crc_step(c, d);
                push_sym(d, i == n - 1);
            end
            exp_res.push_back({c, 8'(n)});
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_done(8, 4000);
        for (int i = 0; i < 8 && i < done_q.size(); i++)
            chk($sformatf("rand_frame[%0d]", i), done_q[i], exp_res[i]);
        cmp_starts(exp_syms);
        chk("val_stable_while_busy", val_viol, 0);

        // Reset in WAIT of the second symbol
        clear_mon();
        busy_len = 11;
        push_sym(5'h03, 1'b0);
        push_sym(5'h04, 1'b0);
        push_sym(5'h05, 1'b1);
        for (int k = 0; k < 200 && started_q.size() < 2; k++) @(negedge clk);
        chk("rst_mid_second_start", started_q.size(), 2);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", bus.s_ready_o, 1);
        repeat (40) @(negedge clk);
        chk("rst_mid_no_done", done_q.size(), 0);
        chk("rst_mid_fifo_empty", started_q.size(), 2);
        push_sym(5'h11, 1'b1);
        wait_done(1, 500);
        if (done_q.size() > 0) begin
            chk("rst_mid_next_len", done_q[0][7:0], 8'd1);
            chk("rst_mid_next_crc", done_q[0][15:8], crc_step(8'h00, 5'h11));
        end

        // Length saturation
        clear_mon();
        busy_len = 0;
        c = 8'h00;
        for (int i = 0; i < 257; i++) begin
            logic [4:0] d;
            d = 5'($urandom);
            c = crc_step(c, d);
            push_sym(d, i == 256);
        end
        wait_done(1, 3000);
        if (done_q.size() > 0) begin
            chk("sat_len", done_q[0][7:0], 8'd255);
            chk("sat_crc", done_q[0][15:8], c);
        end

`ifdef CRC_FEEDER_TIMEOUT_EN
        // Busy stuck high: timeout drops the rest of the frame
        clear_mon();
        busy_len  = 2;
        hold_busy = 1'b1;
        push_sym(5'h07, 1'b0);
        push_sym(5'h08, 1'b0);
        push_sym(5'h09, 1'b1);
        for (int k = 0; k < 200 && to_count < 1; k++) @(negedge clk);
        hold_busy = 1'b0;
        chk("to_count", to_count, 1);
        chk("to_on_wait_cycle_33", to_cyc - last_start, 34);
        push_sym(5'h15, 1'b1);
        wait_done(1, 500);
        exp_syms = '{5'h07, 5'h15};
        cmp_starts(exp_syms);
        if (done_q.size() > 0) begin
            chk("to_next_len", done_q[0][7:0], 8'd1);
            chk("to_next_crc", done_q[0][15:8], crc_step(8'h00, 5'h15));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
